wb_uart_stream_master: RTL and testbench

- Wishbone pipelined master that sits directly upstream of the wbuart slave wrapper.
- Converts two byte streams (TX in, RX out) into register accesses on the UART register map:
  - 0x0 setup
  - 0x4 FIFO status
  - 0x8 RX data
  - 0xC TX data
- Lets hardware (boot loader, debug console) use the UART without the CPU: it polls status, drains the RX FIFO into a one-entry output register and writes TX bytes while the TX FIFO has room.

---
 rtl/wb_uart_stream_master_if.sv | 33 +++
 rtl/wb_uart_stream_master.sv | 230 +++++++++++++++++++++++
 tb/tb_wb_uart_stream_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_stream_master_if.sv
// Wishbone pipelined bus bundle between wb_uart_stream_master and the UART
// register slave. Carries the bus clock and the synchronous active-high reset.
//   clk, rst      : clock and reset, driven by the environment
//   cyc, stb, we  : master cycle, strobe and write enable
//   adr, sel      : byte address and byte lane selects
//   dat_o         : master write data
//   dat_i         : slave read data
//   ack, stall    : slave acknowledge and pipeline stall
//   err           : slave error termination
interface wb_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    input  clk, rst, dat_i, ack, stall, err,
    output cyc, stb, we, adr, sel, dat_o
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, stall, err
  );
endinterface

// File: rtl/wb_uart_stream_master.sv
// Wishbone pipelined master that drives a UART register slave from two byte
// streams. It polls the FIFO status register, drains one RX byte into a
// one-entry output register and writes at most one TX byte per poll round.
// Register map: 0x0 setup, 0x4 FIFO status, 0x8 RX data, 0xC TX data.
// Ports:
//   wb          : Wishbone master (clk/rst are carried in the interface)
//   tx_data_i   : byte to transmit
//   tx_valid_i  : tx_data_i valid
//   tx_ready_o  : byte accepted this cycle
//   rx_data_o   : received byte
//   rx_flags_o  : RX register bits [12:9] captured with the byte
//   rx_valid_o  : rx_data_o valid, held until rx_ready_i
//   rx_ready_i  : consumer accepts the byte
//   bus_err_o   : sticky, set on wb.err or ack timeout
//   dbg_state   : current FSM state
// Stream handshakes: a byte moves on a cycle where valid and ready are both
// high at the clock edge. valid never waits for ready; once rx_valid_o is high
// it and the byte stay put until the edge where rx_ready_i is high. tx_ready_o
// may depend combinationally on tx_valid_i.
module wb_uart_stream_master #(
  parameter logic [30:0] SETUP_VALUE = 31'd25,
  parameter bit          WRITE_SETUP = 1'b0,
  parameter int          POLL_GAP    = 16,
  parameter int          ACK_TIMEOUT = 255
) (
  wb_if.master       wb,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic [3:0] rx_flags_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       bus_err_o,
  output logic [2:0] dbg_state
);

  localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [31:0] ADR_SETUP = 32'h0;
  localparam logic [31:0] ADR_STAT  = 32'h4;
  localparam logic [31:0] ADR_RX    = 32'h8;
  localparam logic [31:0] ADR_TX    = 32'hC;

  typedef enum logic [2:0] {
    S_SETUP, S_GAP, S_STAT, S_DECIDE, S_RXRD, S_TXWR
  } state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic          rx_avail_q, rx_avail_d, tx_room_q, tx_room_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [3:0]    rx_flags_q, rx_flags_d;
  logic          rx_valid_q, rx_valid_d, bus_err_q, bus_err_d;
  logic          done, fail;

  // Status/RX register bits this master does not look at.
  logic unused_dat;
  assign unused_dat = ^{wb.dat_i[31:17], wb.dat_i[15:13]};

  assign wb.cyc     = cyc_q;
  assign wb.stb     = stb_q;
  assign wb.we      = we_q;
  assign wb.adr     = adr_q;
  assign wb.sel     = 4'hF;
  assign wb.dat_o   = dat_q;
  assign rx_data_o  = rx_data_q;
  assign rx_flags_o = rx_flags_q;
  assign rx_valid_o = rx_valid_q;
  assign bus_err_o  = bus_err_q;
  assign dbg_state  = state_q;

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      state_q    <= WRITE_SETUP ? S_SETUP : S_GAP;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      gap_q      <= '0;
      to_q       <= '0;
      rx_avail_q <= 1'b0;
      tx_room_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_flags_q <= '0;
      rx_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      rx_avail_q <= rx_avail_d;
      tx_room_q  <= tx_room_d;
      rx_data_q  <= rx_data_d;
      rx_flags_q <= rx_flags_d;
      rx_valid_q <= rx_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    gap_d      = gap_q;
    to_d       = to_q;
    rx_avail_d = rx_avail_q;
    tx_room_d  = tx_room_q;
    rx_data_d  = rx_data_q;
    rx_flags_d = rx_flags_q;
    rx_valid_d = rx_valid_q;
    bus_err_d  = bus_err_q;
    tx_ready_o = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;

    // Consumer take; a byte loaded in the same cycle below overrides this.
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    // Single outstanding transfer. The timeout counter is loaded with 1 on
    // the acceptance edge, so the abort lands ACK_TIMEOUT edges later.
    // ack/err are only honoured while cyc is high; late ones are ignored.
    if (cyc_q) begin
      if (stb_q && !wb.stall) begin
        stb_d = 1'b0;
        to_d  = TW'(1);
      end
      if (wb.ack) done = 1'b1;
      else if (wb.err) fail = 1'b1;
      else if (!stb_q) begin
        if (to_q == TW'(ACK_TIMEOUT)) fail = 1'b1;
        else to_d = to_q + TW'(1);
      end
      if (done || fail) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end

    // In every bus state the entry cycle has cyc=0 (the mandatory idle
    // cycle); the request is launched on the edge that ends it.
    case (state_q)
      S_SETUP: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
          adr_d = ADR_SETUP; dat_d = {1'b0, SETUP_VALUE};
        end else if (done) begin
          state_d = S_GAP; gap_d = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(POLL_GAP)) state_d = S_STAT;
        else gap_d = gap_q + GW'(1);
      end
      S_STAT: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b0;
          adr_d = ADR_STAT; dat_d = '0;
        end else if (done) begin
          rx_avail_d = wb.dat_i[16];
          tx_room_d  = wb.dat_i[0];
          state_d    = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (rx_avail_q && !rx_valid_q) state_d = S_RXRD;
        else if (tx_room_q && tx_valid_i) state_d = S_TXWR;
        else begin
          state_d = S_GAP; gap_d = '0;
        end
      end
      S_RXRD: begin
        if (!cyc_q) begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b0;
          adr_d = ADR_RX; dat_d = '0;
        end else if (done) begin
          // Bit 8 set means the FIFO was empty after all: drop the word.
          if (!wb.dat_i[8]) begin
            rx_data_d  = wb.dat_i[7:0];
            rx_flags_d = wb.dat_i[12:9];
            rx_valid_d = 1'b1;
          end
          if (tx_room_q && tx_valid_i) state_d = S_TXWR;
          else begin
            state_d = S_GAP; gap_d = '0;
          end
        end
      end
      S_TXWR: begin
        if (!cyc_q) begin
          // Byte taken only on the entry cycle; if the source withdrew it,
          // the round simply ends.
          if (tx_valid_i && !wb.rst) begin
            tx_ready_o = 1'b1;
            cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
            adr_d = ADR_TX; dat_d = {24'h0, tx_data_i};
          end else begin
            state_d = S_GAP; gap_d = '0;
          end
        end else if (done) begin
          state_d = S_GAP; gap_d = '0;
        end
      end
      default: begin
        state_d = S_GAP; gap_d = '0;
      end
    endcase

    // err or timeout aborts the whole round.
    if (fail) begin
      bus_err_d = 1'b1;
      state_d   = S_GAP;
      gap_d     = '0;
    end
  end

endmodule

// File: tb/tb_wb_uart_stream_master.sv
// Directed bench for wb_uart_stream_master: setup write, RX drain, TX write,
// RX back-pressure, slave stall, ack timeout, mid-transfer reset and err.
module tb_wb_uart_stream_master;

  localparam int POLL_GAP    = 4;
  localparam int ACK_TIMEOUT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wb_if wb();
  assign wb.clk = clk;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [3:0] rx_flags;
  logic       rx_valid;
  logic       rx_ready;
  logic       bus_err;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  bit          f;
  logic        w, s;
  logic [31:0] a, d;
  int          idle, rdy, stbc, hold;

  wb_uart_stream_master #(
    .SETUP_VALUE(31'd25),
    .WRITE_SETUP(1'b1),
    .POLL_GAP(POLL_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .wb(wb.master),
    .tx_data_i(tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .rx_data_o(rx_data),
    .rx_flags_o(rx_flags),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .bus_err_o(bus_err),
    .dbg_state(dbg_state)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for cyc; counts idle cycles and tx_ready cycles seen.
  task automatic bus_wait(output bit found, output logic we, output logic stb,
                          output logic [31:0] adr, output logic [31:0] dat,
                          output int idle_n, output int rdy_n);
    found = 0; we = 0; stb = 0; adr = 0; dat = 0; idle_n = 0; rdy_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (wb.cyc) begin
        found = 1; we = wb.we; stb = wb.stb; adr = wb.adr; dat = wb.dat_o;
        break;
      end
      idle_n++;
      if (tx_ready) rdy_n++;
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bus_wait: got no cyc within 200 cycles, want a transfer"); end
  endtask

  // Called on the negedge where a new request is first visible.
  task automatic bus_respond(input int stall_n, input int ack_delay, input bit do_ack,
                             input bit do_err, input logic [31:0] resp,
                             output int stb_cycles, output int hold_n);
    stb_cycles = 1; hold_n = 0;
    wb.stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      if (wb.stb) stb_cycles++;
    end
    wb.stall = 1'b0;
    @(negedge clk);
    if (wb.stb) stb_cycles++;
    for (int i = 0; i < ack_delay; i++) begin
      if (wb.cyc) hold_n++;
      @(negedge clk);
    end
    if (do_ack || do_err) begin
      wb.ack = do_ack; wb.err = do_err; wb.dat_i = resp;
      @(negedge clk);
      wb.ack = 1'b0; wb.err = 1'b0; wb.dat_i = 32'h0;
    end else begin
      for (int i = 0; i < 64 && wb.cyc; i++) begin
        hold_n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    wb.rst = 1'b1; wb.stall = 1'b0; wb.ack = 1'b0; wb.err = 1'b0; wb.dat_i = 32'h0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wb.cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb.cyc); end
    checks++; if (wb.stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb.stb); end
    checks++; if (wb.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb.we); end
    checks++; if (wb.adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", wb.adr); end
    checks++; if (wb.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", wb.dat_o); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h0 || rx_flags !== 4'h0) begin errors++; $display("FAIL reset_rx_reg: got %h/%h want 0/0", rx_data, rx_flags); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    wb.rst = 1'b0;
  endtask

  task automatic test_setup();
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (w !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL setup_req: got we=%b adr=%h want we=1 adr=0", w, a); end
    checks++; if (d !== 32'd25) begin errors++; $display("FAIL setup_dat: got %h want 00000019", d); end
    checks++; if (s !== 1'b1 || wb.sel !== 4'hF) begin errors++; $display("FAIL setup_stb_sel: got stb=%b sel=%h want 1/f", s, wb.sel); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
    checks++; if (stbc != 1) begin errors++; $display("FAIL setup_stb_len: got %0d want 1", stbc); end
    checks++; if (wb.cyc !== 1'b0) begin errors++; $display("FAIL setup_cyc_drop: got %b want 0", wb.cyc); end
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (w !== 1'b0 || a !== 32'h4) begin errors++; $display("FAIL setup_next_stat: got we=%b adr=%h want we=0 adr=4", w, a); end
    // GAP runs POLL_GAP+1 cycles, then STAT spends one idle cycle launching.
    checks++; if (idle != POLL_GAP + 2) begin errors++; $display("FAIL setup_gap: got %0d idle want %0d", idle, POLL_GAP + 2); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
  endtask

  task automatic test_rx();
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL rx_stat_adr: got %h want 4", a); end
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (w !== 1'b0 || a !== 32'h8) begin errors++; $display("FAIL rx_read_req: got we=%b adr=%h want we=0 adr=8", w, a); end
    checks++; if (idle != 2) begin errors++; $display("FAIL rx_read_idle: got %0d want 2", idle); end
    bus_respond(0, 0, 1, 0, 32'h0000_0041, stbc, hold);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h41 || rx_flags !== 4'h0) begin errors++; $display("FAIL rx_byte: got v=%b d=%h f=%h want 1/41/0", rx_valid, rx_data, rx_flags); end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pulse: got valid=%b want 0 after accept", rx_valid); end
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4 || rdy != 0) begin errors++; $display("FAIL rx_no_tx: got adr=%h tx_ready cycles=%0d want adr=4 and 0", a, rdy); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
  endtask

  task automatic test_rx_flags();
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0000_1A33, stbc, hold);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h33 || rx_flags !== 4'hD) begin errors++; $display("FAIL rx_flags: got v=%b d=%h f=%h want 1/33/d", rx_valid, rx_data, rx_flags); end
    @(negedge clk);
  endtask

  task automatic test_rx_empty();
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h8) begin errors++; $display("FAIL empty_read_adr: got %h want 8", a); end
    bus_respond(0, 0, 1, 0, 32'h0000_0100, stbc, hold);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_empty_discard: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_tx();
    tx_data = 8'h5A; tx_valid = 1'b1;
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4 || rdy != 0) begin errors++; $display("FAIL tx_stat: got adr=%h ready=%0d want 4/0", a, rdy); end
    bus_respond(0, 0, 1, 0, 32'h0000_0001, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (rdy != 1) begin errors++; $display("FAIL tx_ready_pulse: got %0d cycles want 1", rdy); end
    checks++; if (w !== 1'b1 || a !== 32'hC || d !== 32'h0000_005A) begin errors++; $display("FAIL tx_write: got we=%b adr=%h dat=%h want 1/c/0000005a", w, a, d); end
    tx_data = 8'hA5;
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4 || rdy != 0) begin errors++; $display("FAIL tx_one_per_round: got adr=%h ready=%0d want 4/0", a, rdy); end
    bus_respond(0, 0, 1, 0, 32'h0000_0001, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (rdy != 1 || a !== 32'hC || d !== 32'h0000_00A5) begin errors++; $display("FAIL tx_second: got ready=%0d adr=%h dat=%h want 1/c/000000a5", rdy, a, d); end
    tx_valid = 1'b0;
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
  endtask

  task automatic test_rx_hold();
    rx_ready = 1'b0;
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0000_0077, stbc, hold);
    for (int r = 0; r < 2; r++) begin
      bus_wait(f, w, s, a, d, idle, rdy);
      checks++; if (a !== 32'h4) begin errors++; $display("FAIL hold_no_read: got adr=%h want 4", a); end
      bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    end
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL hold_no_read_last: got adr=%h want 4", a); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin errors++; $display("FAIL hold_byte: got v=%b d=%h want 1/77", rx_valid, rx_data); end
    rx_ready = 1'b1;
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got valid=%b want 0", rx_valid); end
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h8) begin errors++; $display("FAIL hold_read_after: got adr=%h want 8", a); end
    bus_respond(0, 0, 1, 0, 32'h0000_0042, stbc, hold);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h42) begin errors++; $display("FAIL hold_new_byte: got v=%b d=%h want 1/42", rx_valid, rx_data); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(3, 2, 1, 0, 32'h0, stbc, hold);
    checks++; if (stbc != 4) begin errors++; $display("FAIL stall_stb_len: got %0d want 4", stbc); end
    checks++; if (hold != 2) begin errors++; $display("FAIL stall_cyc_hold: got %0d want 2", hold); end
    checks++; if (wb.cyc !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL stall_end: got cyc=%b err=%b want 0/0", wb.cyc, bus_err); end
  endtask

  task automatic test_timeout();
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 0, 0, 32'h0, stbc, hold);
    checks++; if (hold != ACK_TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d want %0d", hold, ACK_TIMEOUT); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", bus_err); end
    wb.ack = 1'b1; wb.dat_i = 32'h0001_0001;
    @(negedge clk);
    wb.ack = 1'b0; wb.dat_i = 32'h0;
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL timeout_resume: got adr=%h want 4", a); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", bus_err); end
  endtask

  task automatic test_mid_reset();
    rx_ready = 1'b0;
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0001_0000, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 1, 0, 32'h0000_0099, stbc, hold);
    bus_wait(f, w, s, a, d, idle, rdy);
    wb.rst = 1'b1;
    @(negedge clk);
    checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin errors++; $display("FAIL midrst_bus: got cyc=%b stb=%b want 0/0", wb.cyc, wb.stb); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h0) begin errors++; $display("FAIL midrst_rx: got v=%b d=%h want 0/00", rx_valid, rx_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", bus_err); end
    wb.rst = 1'b0; rx_ready = 1'b1;
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (w !== 1'b1 || a !== 32'h0 || d !== 32'd25) begin errors++; $display("FAIL midrst_setup: got we=%b adr=%h dat=%h want 1/0/00000019", w, a, d); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
  endtask

  task automatic test_err();
    bus_wait(f, w, s, a, d, idle, rdy);
    bus_respond(0, 0, 0, 1, 32'h0001_0001, stbc, hold);
    checks++; if (bus_err !== 1'b1 || wb.cyc !== 1'b0) begin errors++; $display("FAIL err_seen: got err=%b cyc=%b want 1/0", bus_err, wb.cyc); end
    bus_wait(f, w, s, a, d, idle, rdy);
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL err_abort_round: got adr=%h want 4", a); end
    bus_respond(0, 0, 1, 0, 32'h0, stbc, hold);
  endtask

  initial begin
    test_reset();
    test_setup();
    test_rx();
    test_rx_flags();
    test_rx_empty();
    test_tx();
    test_rx_hold();
    test_stall();
    test_timeout();
    test_mid_reset();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
